// File: rtl/host_link_pkg.sv
// Shared definitions for the host-side com-port master: FSM states, core idle code, bus widths.
package host_link_pkg;

  localparam int unsigned COM_WIDTH        = 16;
  localparam int unsigned MAX_IN_WORDS_DEF = 1024;
  localparam int unsigned OUT_WORDS_DEF    = 1024;
  localparam int unsigned RD_LAT_DEF       = 1;

  localparam logic [1:0] CORE_IDLE = 2'b11;

  typedef logic [COM_WIDTH-1:0] com_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARM,
    S_GAP,
    S_SEND,
    S_WAIT_PROC,
    S_COLLECT
  } state_t;

endpackage

// File: rtl/host_link_master_tx_buffer.sv
// Job word buffer: simple dual-port RAM, synchronous write, registered read.
module host_tx_buffer
  import host_link_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_IN_WORDS_DEF,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  com_word_t     wdata,
  input  logic [AW-1:0] raddr,
  output com_word_t     rdata
);

  com_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/host_link_master.sv
// Host-side com-port master: buffers one job, replays it to the core, then captures the result stream.
// Optional HOST_LINK_CHECKSUM_EN adds tx_sum/rx_sum running sums of sent and captured words.
module host_link_master
  import host_link_pkg::*;
#(
  parameter int unsigned MAX_IN_WORDS = MAX_IN_WORDS_DEF,
  parameter int unsigned OUT_WORDS    = OUT_WORDS_DEF,
  parameter int unsigned RD_LAT       = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COM_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  input  logic                 src_last,
  output logic                 src_ready,
  output logic [COM_WIDTH-1:0] com_data_in,
  output logic                 data_write_start,
  output logic                 data_write_done,
  input  logic [COM_WIDTH-1:0] com_data_out,
  input  logic [1:0]           core_state,
  input  logic                 output_write_start,
  input  logic                 output_write_done,
  output logic [COM_WIDTH-1:0] snk_data,
  output logic                 snk_valid,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err_trunc,
  output logic                 err_short
`ifdef HOST_LINK_CHECKSUM_EN
  ,
  output logic [COM_WIDTH-1:0] tx_sum,
  output logic [COM_WIDTH-1:0] rx_sum
`endif
);

  localparam int unsigned AW    = $clog2(MAX_IN_WORDS);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned MW    = $clog2(OUT_WORDS + 1);
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t           state, state_next;
  logic [CW-1:0]    n, n_d, k, k_d, k_inc;
  logic [MW-1:0]    m, m_d;
  logic [LAT_W-1:0] lat, lat_d;
  logic             ows_prev;
  logic             beat;
  logic             buf_we;
  logic [AW-1:0]    buf_waddr, buf_raddr;
  com_word_t        rd_data;

  logic             src_ready_d, dws_d, dwd_d, snk_valid_d, busy_d, job_done_d;
  logic             err_trunc_d, err_short_d;
  com_word_t        cdi_d, snk_data_d;

  assign beat  = src_valid & src_ready;
  assign k_inc = k + CW'(1);

  host_tx_buffer #(
    .DEPTH (MAX_IN_WORDS),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (src_data),
    .raddr (buf_raddr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state, buffer control and next values of every registered output
  always_comb begin
    state_next  = state;
    n_d         = n;
    k_d         = k;
    m_d         = m;
    lat_d       = lat;
    buf_we      = 1'b0;
    buf_waddr   = n[AW-1:0];
    buf_raddr   = '0;
    dws_d       = 1'b0;
    dwd_d       = 1'b0;
    cdi_d       = com_data_in;
    snk_data_d  = snk_data;
    snk_valid_d = 1'b0;
    job_done_d  = 1'b0;
    err_trunc_d = err_trunc;
    err_short_d = err_short;

    unique case (state)
      S_IDLE: begin
        if (beat) begin
          buf_we     = 1'b1;
          buf_waddr  = '0;
          n_d        = CW'(1);
          state_next = src_last ? S_ARM : S_FILL;
        end
      end
      S_FILL: begin
        if (beat) begin
          if (n < CW'(MAX_IN_WORDS)) begin
            buf_we = 1'b1;
            n_d    = n + CW'(1);
          end else begin
            err_trunc_d = 1'b1;
          end
          if (src_last) state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (core_state == CORE_IDLE) begin
          dws_d      = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        buf_raddr  = '0;
        k_d        = '0;
        state_next = S_SEND;
      end
      // Read address runs one word ahead of the word being loaded into com_data_in
      S_SEND: begin
        buf_raddr = k_inc[AW-1:0];
        cdi_d     = rd_data;
        k_d       = k_inc;
        if (k == n - CW'(1)) begin
          dwd_d      = 1'b1;
          state_next = S_WAIT_PROC;
        end
      end
      S_WAIT_PROC: begin
        if (output_write_start && !ows_prev) begin
          m_d        = '0;
          lat_d      = LAT_W'(RD_LAT - 1);
          state_next = S_COLLECT;
        end
      end
      // The done-pulse cycle carries no result word
      S_COLLECT: begin
        if (output_write_done) begin
          job_done_d = 1'b1;
          if (m < MW'(OUT_WORDS)) err_short_d = 1'b1;
          state_next = S_IDLE;
        end else if (lat != '0) begin
          lat_d = lat - LAT_W'(1);
        end else if (m < MW'(OUT_WORDS)) begin
          snk_data_d  = com_data_out;
          snk_valid_d = 1'b1;
          m_d         = m + MW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    src_ready_d = (state_next == S_IDLE) || (state_next == S_FILL);
    busy_d      = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n                <= '0;
      k                <= '0;
      m                <= '0;
      lat              <= '0;
      ows_prev         <= 1'b0;
      src_ready        <= 1'b0;
      com_data_in      <= '0;
      data_write_start <= 1'b0;
      data_write_done  <= 1'b0;
      snk_data         <= '0;
      snk_valid        <= 1'b0;
      busy             <= 1'b0;
      job_done         <= 1'b0;
      err_trunc        <= 1'b0;
      err_short        <= 1'b0;
    end else begin
      n                <= n_d;
      k                <= k_d;
      m                <= m_d;
      lat              <= lat_d;
      ows_prev         <= output_write_start;
      src_ready        <= src_ready_d;
      com_data_in      <= cdi_d;
      data_write_start <= dws_d;
      data_write_done  <= dwd_d;
      snk_data         <= snk_data_d;
      snk_valid        <= snk_valid_d;
      busy             <= busy_d;
      job_done         <= job_done_d;
      err_trunc        <= err_trunc_d;
      err_short        <= err_short_d;
    end
  end

`ifdef HOST_LINK_CHECKSUM_EN
  // Sums restart with each job start and freeze once the job completes
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sum <= '0;
      rx_sum <= '0;
    end else if (dws_d) begin
      tx_sum <= '0;
      rx_sum <= '0;
    end else begin
      if (state == S_SEND) tx_sum <= tx_sum + rd_data;
      if (snk_valid_d)     rx_sum <= rx_sum + snk_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_host_link_master.sv
// Directed scoreboard bench for host_link_master: job replay framing, truncation, short results, reset abort.
module tb_host_link_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_data;
  logic        src_valid, src_last, src_ready;
  logic [15:0] com_data_in;
  logic        data_write_start, data_write_done;
  logic [15:0] com_data_out;
  logic [1:0]  core_state;
  logic        output_write_start, output_write_done;
  logic [15:0] snk_data;
  logic        snk_valid, busy, job_done, err_trunc, err_short;
`ifdef HOST_LINK_CHECKSUM_EN
  logic [15:0] tx_sum, rx_sum;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] q_tx[$];
  logic [15:0] q_rx[$];

  host_link_master dut (
    .clk                (clk),
    .rst                (rst),
    .src_data           (src_data),
    .src_valid          (src_valid),
    .src_last           (src_last),
    .src_ready          (src_ready),
    .com_data_in        (com_data_in),
    .data_write_start   (data_write_start),
    .data_write_done    (data_write_done),
    .com_data_out       (com_data_out),
    .core_state         (core_state),
    .output_write_start (output_write_start),
    .output_write_done  (output_write_done),
    .snk_data           (snk_data),
    .snk_valid          (snk_valid),
    .busy               (busy),
    .job_done           (job_done),
    .err_trunc          (err_trunc),
    .err_short          (err_short)
`ifdef HOST_LINK_CHECKSUM_EN
    ,
    .tx_sum             (tx_sum),
    .rx_sum             (rx_sum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [15:0] d, input logic last, input logic keep);
    src_valid = 1'b1;
    src_data  = d;
    src_last  = last;
    if (keep) q_tx.push_back(d);
    tick();
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int t = 0;
    while (data_write_start !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk(tag, 64'(data_write_start), 64'd1);
  endtask

  // Called with the start pulse visible: expect one gap cycle, then queued words back to back
  task automatic check_tx(input string tag);
    logic [15:0] e;
    tick();
    chk({tag, "_gap_start"}, 64'(data_write_start), 64'd0);
    chk({tag, "_gap_done"}, 64'(data_write_done), 64'd0);
    while (q_tx.size() > 0) begin
      e = q_tx.pop_front();
      tick();
      chk({tag, "_word"}, 64'(com_data_in), 64'(e));
      chk({tag, "_done"}, 64'(data_write_done), 64'(q_tx.size() == 0));
    end
  endtask

  // Raise output_write_start, stream nw words (valid one cycle after the rise), then pulse done
  task automatic collect(input string tag, input int nw, input int n_extra, input logic exp_short);
    logic [15:0] e;
    output_write_start = 1'b0;
    tick();
    output_write_start = 1'b1;
    tick();
    for (int j = 0; j < nw; j++) begin
      com_data_out = 16'(j);
      q_rx.push_back(16'(j));
      tick();
      e = q_rx.pop_front();
      chk({tag, "_snk_valid"}, 64'(snk_valid), 64'd1);
      chk({tag, "_snk_data"}, 64'(snk_data), 64'(e));
    end
    for (int j = 0; j < n_extra; j++) begin
      com_data_out = 16'hBEEF;
      tick();
      chk({tag, "_snk_full"}, 64'(snk_valid), 64'd0);
    end
    com_data_out      = 16'hFFFF;
    output_write_done = 1'b1;
    tick();
    output_write_done = 1'b0;
    chk({tag, "_job_done"}, 64'(job_done), 64'd1);
    chk({tag, "_snk_idle"}, 64'(snk_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err_short"}, 64'(err_short), 64'(exp_short));
    tick();
    chk({tag, "_job_done_pulse"}, 64'(job_done), 64'd0);
    chk({tag, "_ready"}, 64'(src_ready), 64'd1);
  endtask

  initial begin
    rst                = 1'b1;
    src_data           = '0;
    src_valid          = 1'b0;
    src_last           = 1'b0;
    com_data_out       = '0;
    core_state         = 2'b11;
    output_write_start = 1'b0;
    output_write_done  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {src_ready, com_data_in, data_write_start, data_write_done, snk_data,
         snk_valid, busy, job_done, err_trunc, err_short}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(src_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // 4-word job, full result stream
    for (int i = 0; i < 4; i++) push_beat(16'((i + 1) * 16'h1111), i == 3, 1'b1);
    chk("j1_arm_busy", 64'(busy), 64'd1);
    chk("j1_arm_ready", 64'(src_ready), 64'd0);
    wait_start("j1_start");
    check_tx("j1");
    collect("j1", 1024, 0, 1'b0);
    chk("j1_err_trunc", 64'(err_trunc), 64'd0);

    // 1-word job; core busy holds back the start, stray src beat ignored while armed
    core_state = 2'b01;
    push_beat(16'hABCD, 1'b1, 1'b1);
    src_valid = 1'b1;
    src_data  = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j2_start_held", 64'(data_write_start), 64'd0);
      chk("j2_ready_low", 64'(src_ready), 64'd0);
    end
    core_state = 2'b11;
    tick();
    src_valid = 1'b0;
    chk("j2_start", 64'(data_write_start), 64'd1);
    check_tx("j2");
    collect("j2_short", 500, 0, 1'b1);

    // 1030-word job: only 1024 buffered and sent
    chk("j3_trunc_before", 64'(err_trunc), 64'd0);
    for (int i = 0; i < 1030; i++) begin
      if (i == 1029) chk("j3_ready_dropping", 64'(src_ready), 64'd1);
      push_beat(16'(16'h2000 + i), i == 1029, i < 1024);
    end
    chk("j3_trunc_after", 64'(err_trunc), 64'd1);
    wait_start("j3_start");
    check_tx("j3");
    tick();
    chk("j3_no_extra_done", 64'(data_write_done), 64'd0);
    chk("j3_wait_busy", 64'(busy), 64'd1);
    collect("j3", 1024, 1, 1'b1);

    // Reset in the middle of SEND aborts the job
    for (int i = 0; i < 4; i++) push_beat(16'(16'h7000 + i), i == 3, 1'b1);
    wait_start("j4_start");
    tick();
    tick();
    chk("j4_first_word", 64'(com_data_in), 64'h7000);
    rst                = 1'b1;
    output_write_start = 1'b0;
    tick();
    chk("j4_reset_outputs",
        {src_ready, com_data_in, data_write_start, data_write_done, snk_data,
         snk_valid, busy, job_done, err_trunc, err_short}, 64'd0);
    rst = 1'b0;
    q_tx.delete();
    tick();
    chk("j4_ready_after", 64'(src_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
